// File: rtl/led_fade_driver.sv
// Per-channel LED fader: brightness levels ramp toward the registered pattern
// bit on prescaled ticks and are rendered as PWM from a shared counter.
module led_fade_driver #(
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 65536,
  parameter int CHANNELS = 4
) (
  input  logic                CLK_66MHZ,
  input  logic                USER_RESET,
  input  logic [CHANNELS-1:0] pattern_in,
  input  logic                hold,
  output logic [CHANNELS-1:0] LED,
  output logic                ramp_busy
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};

  logic [CHANNELS-1:0]                pattern_q_reg;
  logic [PRE_W-1:0]                   prescaler_reg;
  logic [PWM_BITS-1:0]                pwm_cnt_reg;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  level_reg;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  level_next;
  logic [CHANNELS-1:0]                led_reg;
  logic [CHANNELS-1:0]                led_next;
  logic [CHANNELS-1:0]                busy;
  logic                               prescaler_wrap;
  logic                               tick;

  // The prescaler free-runs through hold; only the step itself is suppressed.
  assign prescaler_wrap = (prescaler_reg == PRE_LAST);
  assign tick           = prescaler_wrap & ~hold;

  always_ff @(posedge CLK_66MHZ) begin
    if (USER_RESET) begin
      pattern_q_reg <= '0;
      prescaler_reg <= '0;
      pwm_cnt_reg   <= '0;
      level_reg     <= '0;
      led_reg       <= '0;
    end else begin
      pattern_q_reg <= pattern_in;
      prescaler_reg <= prescaler_wrap ? '0 : prescaler_reg + 1'b1;
      pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
      level_reg     <= level_next;
      led_reg       <= led_next;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic step_up;
      logic step_down;

      // Saturating step: reversal simply continues from the current level.
      assign step_up   = tick &  pattern_q_reg[gi] & (level_reg[gi] != MAX);
      assign step_down = tick & ~pattern_q_reg[gi] & (level_reg[gi] != '0);

      assign level_next[gi] = step_up   ? level_reg[gi] + 1'b1 :
                              step_down ? level_reg[gi] - 1'b1 :
                                          level_reg[gi];

      // Full scale is forced on so MAX gives a constant 1 rather than MAX/2^N.
      assign led_next[gi] = (level_reg[gi] == MAX) | (pwm_cnt_reg < level_reg[gi]);

      assign busy[gi] = pattern_q_reg[gi] ? (level_reg[gi] != MAX)
                                          : (level_reg[gi] != '0);
    end
  endgenerate

  assign LED       = led_reg;
  assign ramp_busy = |busy;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver: a slow-ramp instance (RAMP_DIV=4) and a
// per-cycle-ramp instance (RAMP_DIV=1), both with PWM_BITS=4.
module tb_led_fade_driver;

  logic       clk;
  logic       rst;
  logic [3:0] pat;
  logic       hold;
  logic [3:0] led;
  logic       busy;

  logic       rst_f;
  logic [3:0] pat_f;
  logic       hold_f;
  logic [3:0] led_f;
  logic       busy_f;

  int checks;
  int errors;

  led_fade_driver #(.PWM_BITS(4), .RAMP_DIV(4), .CHANNELS(4)) dut (
    .CLK_66MHZ (clk),
    .USER_RESET(rst),
    .pattern_in(pat),
    .hold      (hold),
    .LED       (led),
    .ramp_busy (busy)
  );

  led_fade_driver #(.PWM_BITS(4), .RAMP_DIV(1), .CHANNELS(4)) dut_fast (
    .CLK_66MHZ (clk),
    .USER_RESET(rst_f),
    .pattern_in(pat_f),
    .hold      (hold_f),
    .LED       (led_f),
    .ramp_busy (busy_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] pat;
    logic       hold;
    logic [3:0] exp_led;
    logic       exp_busy;
    logic [3:0] exp_lvl0;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic reset_with(input logic [3:0] p);
    rst  = 1'b1;
    pat  = p;
    hold = 1'b0;
    step();
    rst  = 1'b0;
  endtask

  initial begin
    int highs;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    pat    = 4'h0;
    hold   = 1'b0;
    rst_f  = 1'b1;
    pat_f  = 4'h0;
    hold_f = 1'b0;

    // Reset held 3 cycles then released with pattern F: first step on edge 4.
    vecs[0] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'd0};
    vecs[1] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'd0};
    vecs[2] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'd0};
    vecs[3] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 4'd0};
    vecs[4] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 4'd0};
    vecs[5] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 4'd0};
    vecs[6] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 4'd1};
    vecs[7] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 4'd1};

    for (int i = 0; i < 8; i++) begin
      rst  = vecs[i].rst;
      pat  = vecs[i].pat;
      hold = vecs[i].hold;
      step();
      check($sformatf("t1_led[%0d]", i),  led,                 vecs[i].exp_led);
      check($sformatf("t1_busy[%0d]", i), busy,                vecs[i].exp_busy);
      check($sformatf("t1_lvl0[%0d]", i), dut.level_reg[0],    vecs[i].exp_lvl0);
    end

    // Single channel ramps to full in 15 ticks (60 cycles), then LED solid on.
    reset_with(4'b0001);
    for (int n = 1; n <= 60; n++) begin
      step();
      if (led[3:1] != 3'b000) check("t2_led_hi_off", led[3:1], 0);
      if (n == 59) begin
        check("t2_lvl_n59", dut.level_reg[0], 14);
        check("t2_busy_n59", busy, 1);
      end
      if (n == 60) begin
        check("t2_lvl_n60", dut.level_reg[0], 15);
        check("t2_busy_n60", busy, 0);
      end
    end
    highs = 0;
    for (int n = 61; n <= 92; n++) begin
      step();
      if (led == 4'b0001) highs++;
    end
    check("t2_led_solid_cycles", highs, 32);

    // Level 5 frozen by hold: 5 high cycles per 16, one cycle after pwm 0..4.
    reset_with(4'b0001);
    for (int n = 1; n <= 20; n++) step();
    check("t3_lvl_before_hold", dut.level_reg[0], 5);
    hold = 1'b1;
    highs = 0;
    for (int n = 21; n <= 52; n++) begin
      step();
      if (led[0] !== (((n - 1) % 16) < 5)) check($sformatf("t3_pwm_n%0d", n), led[0], ((n - 1) % 16) < 5);
      if (led[0]) highs++;
    end
    check("t3_high_cycles", highs, 10);
    check("t3_lvl_frozen", dut.level_reg[0], 5);
    hold = 1'b0;

    // Reverse at level 7: next tick gives 6, then down to 0 with no wrap.
    reset_with(4'b0001);
    for (int n = 1; n <= 28; n++) step();
    check("t4_lvl_at7", dut.level_reg[0], 7);
    pat = 4'b0000;
    for (int n = 29; n <= 72; n++) begin
      step();
      if (n == 31) check("t4_lvl_n31", dut.level_reg[0], 7);
      if (n == 32) check("t4_lvl_reverse", dut.level_reg[0], 6);
      if (n == 55) check("t4_busy_n55", busy, 1);
      if (n == 56) begin
        check("t4_lvl_zero", dut.level_reg[0], 0);
        check("t4_busy_n56", busy, 0);
      end
    end
    check("t4_lvl_no_wrap", dut.level_reg[0], 0);
    check("t4_led_off", led, 0);

    // Reset mid-ramp on channel 2 at level 9.
    reset_with(4'b0100);
    for (int n = 1; n <= 38; n++) step();
    check("t5_lvl2_mid", dut.level_reg[2], 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_lvl2_reset", dut.level_reg[2], 0);
    check("t5_led_reset", led, 0);
    check("t5_pwm_reset", dut.pwm_cnt_reg, 0);
    check("t5_pre_reset", dut.prescaler_reg, 0);
    for (int n = 1; n <= 4; n++) begin
      step();
      if (n == 3) check("t5_lvl2_n3", dut.level_reg[2], 0);
      if (n == 4) check("t5_lvl2_restart", dut.level_reg[2], 1);
    end

    // RAMP_DIV=1: step every cycle, hold for 3 cycles freezes exactly 3.
    rst   = 1'b1;
    rst_f = 1'b1;
    pat_f = 4'hF;
    step();
    rst_f = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      int exp_lvl;
      hold_f = (n >= 7 && n <= 9);
      step();
      if (n <= 6)      exp_lvl = n - 1;
      else if (n <= 9) exp_lvl = 5;
      else             exp_lvl = n - 4;
      check($sformatf("t6_lvl0_n%0d", n), dut_fast.level_reg[0], exp_lvl);
      if (n == 19) begin
        check("t6_lvl3_full", dut_fast.level_reg[3], 15);
        check("t6_busy_done", busy_f, 0);
      end
    end
    hold_f = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream stage of the LED flasher counter: consumes the 4-bit LED pattern (counter bits) and drives the board LEDs.
- Each LED fades smoothly instead of switching hard: a per-channel brightness level ramps toward full-on or off, following the pattern bit.
- The level is rendered as PWM from a shared free-running counter.
- Sits between the pattern source and the LED pins, in the same clock domain.

Parameters:
- PWM_BITS, 8: width of the PWM counter and of each brightness level; MAX = 2^PWM_BITS-1.
- RAMP_DIV, 65536: clock cycles per ramp step; must be >= 1.
- CHANNELS, 4: number of LED channels.

Ports:
- CLK_66MHZ  input  1  system clock.
- USER_RESET  input  1  synchronous, active-high reset.
- pattern_in  input  CHANNELS  target on/off per LED, sampled every cycle.
- hold  input  1  when 1, ramp steps are suppressed; PWM keeps running.
- LED  output  CHANNELS  PWM-dimmed LED drive, registered.
- ramp_busy  output  1  1 while any channel's level differs from its target endpoint.

Behaviour:
- Single clock (CLK_66MHZ). Reset is synchronous, active-high (USER_RESET), and is sampled on the rising edge.
- Reset values: pattern_q=0, prescaler=0, pwm_cnt=0, all level[i]=0, LED=0. ramp_busy therefore reads 0 after reset.
- Input stage: pattern_q <= pattern_in every cycle (one register stage). All ramp decisions use pattern_q.
- Prescaler:
  - Counts 0..RAMP_DIV-1 and wraps to 0; it keeps counting while hold=1.
  - tick = (prescaler == RAMP_DIV-1) & ~hold. It is combinational, one cycle wide.
  - With RAMP_DIV=1, tick=~hold every cycle.
- Ramp, on a tick cycle, for each channel i:
  - pattern_q[i]=1 and level[i]<MAX: level[i]+1.
  - pattern_q[i]=0 and level[i]>0: level[i]-1.
  - Otherwise level[i] is unchanged. Saturates at both ends; never wraps.
  - No tick: levels hold.
- Pattern change mid-ramp: the direction reverses on the next tick from the current level. There is no restart and no jump.
- PWM:
  - pwm_cnt increments every cycle, PWM_BITS wide, and wraps MAX->0. It is unaffected by hold.
  - LED[i] <= (level[i]==MAX) | (pwm_cnt < level[i]).
  - The value registered uses the pre-edge values of pwm_cnt and level, so LED has 1 cycle latency from level/pwm_cnt.
  - Duty per 2^PWM_BITS period: level=0 gives constant 0; 0<level<MAX gives exactly level high cycles; level=MAX gives constant 1.
- ramp_busy: combinational from registers. It is the OR over i of (pattern_q[i] ? level[i]!=MAX : level[i]!=0).
- Latency, pattern_in change to first level step:
  - 1 cycle for the pattern_q stage, then wait for the next tick, i.e. at most RAMP_DIV cycles after that.
  - A full ramp 0->MAX takes MAX ticks.
- Reset mid-ramp: everything returns to its reset value on the next edge. The first tick after reset occurs RAMP_DIV cycles after reset deasserts.
- Simultaneous hold deassert and prescaler==RAMP_DIV-1: the tick is taken in that cycle.

Test Plan (bench uses PWM_BITS=4 so MAX=15, RAMP_DIV=4, CHANNELS=4):
1. Reset held 3 cycles, pattern_in=4'hF:
   - LED=0, level=0, ramp_busy=0 during reset.
   - After release, ramp_busy=1 from the cycle pattern_q=F.
   - First level step at prescaler wrap, 4 cycles after release.
2. pattern_in=4'b0001 constant from reset:
   - level[0] reaches 15 after 15 ticks (60 cycles); ramp_busy then drops to 0.
   - LED[0] is constantly 1 thereafter; LED[3:1] stay 0.
3. Force level[0]=5, hold=1, pattern_q[0]=1:
   - level frozen.
   - LED[0] high for exactly 5 of every 16 cycles, aligned one cycle after pwm_cnt=0..4.
4. Ramp up to level 7, then set pattern_in[0]=0:
   - Next tick gives level 6, not 8.
   - Continues to 0 and saturates; the next ticks leave it at 0 with no wrap to 15.
5. Assert USER_RESET for 1 cycle while level[2]=9 mid-ramp:
   - Next edge: level[2]=0, LED=0, pwm_cnt=0, prescaler=0.
   - Ramp restarts normally.
6. RAMP_DIV=1 build, pattern 4'hF:
   - levels step every cycle and reach 15 in 15 cycles.
   - hold=1 for 3 cycles during the ramp freezes the level exactly 3 cycles.
